// File: rtl/timer_unit.sv
// rtl/timer_unit.sv - 8051-style dual timer/counter with TCON/TMOD/TLx/THx SFR access
module timer_unit #(
  parameter int PRESCALE = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sfr_addr,
  input  logic [7:0] sfr_wdata,
  input  logic       sfr_we,
  output logic [7:0] sfr_rdata,
  input  logic       t0_pin,
  input  logic       t1_pin,
  input  logic       int0_n,
  input  logic       int1_n,
  input  logic       tf0_ack,
  input  logic       tf1_ack,
  output logic       tf0_irq,
  output logic       tf1_irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [7:0] A_TCON = 8'h88;
  localparam logic [7:0] A_TMOD = 8'h89;
  localparam logic [7:0] A_TL0  = 8'h8A;
  localparam logic [7:0] A_TL1  = 8'h8B;
  localparam logic [7:0] A_TH0  = 8'h8C;
  localparam logic [7:0] A_TH1  = 8'h8D;

  logic [7:0]    r_tcon, r_tmod, r_tl0, r_tl1, r_th0, r_th1;
  logic [PW-1:0] r_pre;
  logic          r_s0, r_s1;

  logic          w_tick, w_fall0, w_fall1, w_run0, w_run1, w_ev0, w_ev1;
  logic [1:0]    w_m0, w_m1;
  logic [16:0]   w_a0, w_a1;
  logic          w_th0_ev, w_set0, w_set1;
  logic [7:0]    w_th0_nx, w_tcon_nx;
  logic          w_we_tcon;

  // Returns {overflow, th_next, tl_next}; mode 3 advances only TL (TH0 is handled separately).
  function automatic logic [16:0] f_adv(input logic [1:0] mode, input logic ev,
                                        input logic [7:0] th, input logic [7:0] tl);
    logic [13:0] c13;
    logic [16:0] c16;
    logic [8:0]  c8;
    c13   = {1'b0, th, tl[4:0]} + 14'd1;
    c16   = {1'b0, th, tl} + 17'd1;
    c8    = {1'b0, tl} + 9'd1;
    f_adv = {1'b0, th, tl};
    if (ev) begin
      case (mode)
        2'd0:    f_adv = {c13[13], c13[12:5], tl[7:5], c13[4:0]};
        2'd1:    f_adv = c16;
        2'd2:    f_adv = (tl == 8'hFF) ? {1'b1, th, th} : {1'b0, th, c8[7:0]};
        default: f_adv = {c8[8], th, c8[7:0]};
      endcase
    end
    return f_adv;
  endfunction

  assign w_tick  = (r_pre == PW'(PRESCALE - 1));
  assign w_fall0 = w_tick & r_s0 & ~t0_pin;
  assign w_fall1 = w_tick & r_s1 & ~t1_pin;
  assign w_run0  = r_tcon[4] & (~r_tmod[3] | int0_n);
  assign w_run1  = r_tcon[6] & (~r_tmod[7] | int1_n);
  assign w_ev0   = w_run0 & (r_tmod[2] ? w_fall0 : w_tick);
  assign w_ev1   = w_run1 & (r_tmod[6] ? w_fall1 : w_tick);
  assign w_m0    = r_tmod[1:0];
  assign w_m1    = r_tmod[5:4];

  // Timer 1 parked in mode 3 simply holds its count.
  assign w_a0     = f_adv(w_m0, w_ev0, r_th0, r_tl0);
  assign w_a1     = f_adv(w_m1, w_ev1 & (w_m1 != 2'd3), r_th1, r_tl1);
  assign w_th0_ev = (w_m0 == 2'd3) & w_tick & r_tcon[6];
  assign w_th0_nx = w_th0_ev ? r_th0 + 8'd1 : w_a0[15:8];
  assign w_set0   = w_a0[16];
  assign w_set1   = w_a1[16] | (w_th0_ev & (r_th0 == 8'hFF));
  assign w_we_tcon = sfr_we & (sfr_addr == A_TCON);

  // Hardware flag set outranks both a CPU write and an acknowledge.
  always_comb begin
    w_tcon_nx = w_we_tcon ? sfr_wdata : r_tcon;
    if (!w_we_tcon && tf0_ack) w_tcon_nx[5] = 1'b0;
    if (!w_we_tcon && tf1_ack) w_tcon_nx[7] = 1'b0;
    if (w_set0) w_tcon_nx[5] = 1'b1;
    if (w_set1) w_tcon_nx[7] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tcon <= 8'h00;
      r_tmod <= 8'h00;
      r_tl0  <= 8'h00;
      r_tl1  <= 8'h00;
      r_th0  <= 8'h00;
      r_th1  <= 8'h00;
      r_pre  <= '0;
      r_s0   <= 1'b1;
      r_s1   <= 1'b1;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) begin
        r_s0 <= t0_pin;
        r_s1 <= t1_pin;
      end
      r_tcon <= w_tcon_nx;
      r_tmod <= (sfr_we && sfr_addr == A_TMOD) ? sfr_wdata : r_tmod;
      r_tl0  <= (sfr_we && sfr_addr == A_TL0)  ? sfr_wdata : w_a0[7:0];
      r_th0  <= (sfr_we && sfr_addr == A_TH0)  ? sfr_wdata : w_th0_nx;
      r_tl1  <= (sfr_we && sfr_addr == A_TL1)  ? sfr_wdata : w_a1[7:0];
      r_th1  <= (sfr_we && sfr_addr == A_TH1)  ? sfr_wdata : w_a1[15:8];
    end
  end

  always_comb begin
    case (sfr_addr)
      A_TCON:  sfr_rdata = r_tcon;
      A_TMOD:  sfr_rdata = r_tmod;
      A_TL0:   sfr_rdata = r_tl0;
      A_TL1:   sfr_rdata = r_tl1;
      A_TH0:   sfr_rdata = r_th0;
      A_TH1:   sfr_rdata = r_th1;
      default: sfr_rdata = 8'h00;
    endcase
  end

  assign tf0_irq = r_tcon[5];
  assign tf1_irq = r_tcon[7];

endmodule

// File: tb/tb_timer_unit.sv
// tb/tb_timer_unit.sv - directed and randomized checks of timer_unit against an arithmetic model
module tb_timer_unit;
  localparam int P = 12;

  logic       clk = 1'b0;
  logic       rst_n, sfr_we, t0_pin, t1_pin, int0_n, int1_n, tf0_ack, tf1_ack;
  logic [7:0] sfr_addr, sfr_wdata;
  logic [7:0] sfr_rdata;
  logic       tf0_irq, tf1_irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: register values as plain integers, prescale phase, pin samples, tick count.
  int m_tcon, m_tmod, m_tl0, m_tl1, m_th0, m_th1, m_pre, m_ticks;
  bit m_s0, m_s1;

  timer_unit #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .sfr_addr(sfr_addr), .sfr_wdata(sfr_wdata), .sfr_we(sfr_we),
    .sfr_rdata(sfr_rdata), .t0_pin(t0_pin), .t1_pin(t1_pin), .int0_n(int0_n), .int1_n(int1_n),
    .tf0_ack(tf0_ack), .tf1_ack(tf1_ack), .tf0_irq(tf0_irq), .tf1_irq(tf1_irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bitof(input int v, input int b);
    return (v >> b) & 1;
  endfunction

  // Counting rule for one timer, as a number line of the selected width.
  task automatic count_up(input int mode, input bit ev, input int th, input int tl,
                          output bit ovf, output int nth, output int ntl);
    int v;
    ovf = 0; nth = th; ntl = tl;
    if (!ev) return;
    case (mode)
      0: begin
        v = th * 32 + tl % 32 + 1;
        if (v == 8192) begin v = 0; ovf = 1; end
        nth = v / 32; ntl = (tl / 32) * 32 + v % 32;
      end
      1: begin
        v = th * 256 + tl + 1;
        if (v == 65536) begin v = 0; ovf = 1; end
        nth = v / 256; ntl = v % 256;
      end
      2: if (tl == 255) begin ntl = th; ovf = 1; end else ntl = tl + 1;
      default: begin ntl = (tl + 1) % 256; ovf = (tl == 255); end
    endcase
  endtask

  task automatic model_edge();
    bit tick, f0, f1, run0, run1, ev0, ev1, set0, set1, o;
    int n_tl0, n_th0, n_tl1, n_th1, md0, md1, n_tcon;
    if (!rst_n) begin
      m_tcon = 0; m_tmod = 0; m_tl0 = 0; m_tl1 = 0; m_th0 = 0; m_th1 = 0; m_pre = 0;
      m_s0 = 1; m_s1 = 1;
      return;
    end
    tick  = (m_pre == P - 1);
    m_pre = (m_pre + 1) % P;
    if (tick) m_ticks++;
    f0 = tick && m_s0 && !t0_pin;
    f1 = tick && m_s1 && !t1_pin;
    if (tick) begin m_s0 = t0_pin; m_s1 = t1_pin; end
    run0 = bitof(m_tcon, 4) && (!bitof(m_tmod, 3) || int0_n);
    run1 = bitof(m_tcon, 6) && (!bitof(m_tmod, 7) || int1_n);
    ev0  = run0 && (bitof(m_tmod, 2) ? f0 : tick);
    ev1  = run1 && (bitof(m_tmod, 6) ? f1 : tick);
    md0  = m_tmod % 4;
    md1  = (m_tmod / 16) % 4;
    count_up(md0, ev0, m_th0, m_tl0, set0, n_th0, n_tl0);
    count_up(md1, ev1 && md1 != 3, m_th1, m_tl1, set1, n_th1, n_tl1);
    if (md0 == 3 && tick && bitof(m_tcon, 6)) begin
      if (m_th0 == 255) set1 = 1;
      n_th0 = (m_th0 + 1) % 256;
    end
    n_tcon = m_tcon;
    if (sfr_we) begin
      case (sfr_addr)
        8'h88: n_tcon = sfr_wdata;
        8'h89: m_tmod = sfr_wdata;
        8'h8A: n_tl0 = sfr_wdata;
        8'h8B: n_tl1 = sfr_wdata;
        8'h8C: n_th0 = sfr_wdata;
        8'h8D: n_th1 = sfr_wdata;
        default: ;
      endcase
    end
    if (!(sfr_we && sfr_addr == 8'h88)) begin
      if (tf0_ack) n_tcon = n_tcon & ~32'h20;
      if (tf1_ack) n_tcon = n_tcon & ~32'h80;
    end
    if (set0) n_tcon = n_tcon | 32'h20;
    if (set1) n_tcon = n_tcon | 32'h80;
    m_tcon = n_tcon; m_tl0 = n_tl0; m_th0 = n_th0; m_tl1 = n_tl1; m_th1 = n_th1;
  endtask

  function automatic logic [7:0] m_reg(input logic [7:0] a);
    case (a)
      8'h88: return 8'(m_tcon);
      8'h89: return 8'(m_tmod);
      8'h8A: return 8'(m_tl0);
      8'h8B: return 8'(m_tl1);
      8'h8C: return 8'(m_th0);
      8'h8D: return 8'(m_th1);
      default: return 8'h00;
    endcase
  endfunction

  task automatic step(input bit we, input logic [7:0] a, input logic [7:0] d);
    sfr_we = we; sfr_addr = a; sfr_wdata = d;
    model_edge();
    @(posedge clk);
    #1;
    sfr_we = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    sfr_addr = a;
    #1;
    v = sfr_rdata;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] v;
    for (int a = 8'h88; a <= 8'h8D; a++) begin
      rd(8'(a), v);
      chk($sformatf("%s sfr%h", tag, a), v, m_reg(8'(a)));
    end
    rd(8'h90, v);
    chk({tag, " unmapped"}, v, 8'h00);
    chk({tag, " tf0_irq"}, {7'd0, tf0_irq}, 8'(bitof(m_tcon, 5)));
    chk({tag, " tf1_irq"}, {7'd0, tf1_irq}, 8'(bitof(m_tcon, 7)));
  endtask

  task automatic wait_ticks(input int n);
    int target = m_ticks + n;
    int b = 0;
    while (m_ticks < target && b < n * P + 4) begin run(1); b++; end
    chk("wait_ticks bound", 8'(m_ticks >= target), 8'h01);
  endtask

  task automatic wait_next_tick();
    int b = 0;
    while (m_pre != P - 1 && b < P) begin run(1); b++; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    int b;
    rst_n = 0; sfr_we = 0; sfr_addr = 0; sfr_wdata = 0;
    t0_pin = 1; t1_pin = 1; int0_n = 1; int1_n = 1; tf0_ack = 0; tf1_ack = 0;
    m_ticks = 0;

    do_reset();
    for (int a = 8'h88; a <= 8'h8D; a++) begin rd(8'(a), v); chk("reset sfr", v, 8'h00); end
    chk("reset irqs", {6'd0, tf1_irq, tf0_irq}, 8'h00);

    // Mode 1 rollover from 0xFFFE
    step(1, 8'h89, 8'h01); step(1, 8'h8C, 8'hFF); step(1, 8'h8A, 8'hFE); step(1, 8'h88, 8'h10);
    wait_ticks(2);
    rd(8'h8A, v); chk("m1 TL0", v, 8'h00);
    rd(8'h8C, v); chk("m1 TH0", v, 8'h00);
    chk("m1 tf0_irq", {7'd0, tf0_irq}, 8'h01);
    check_all("m1");

    // Mode 2 auto-reload, then acknowledge
    do_reset();
    step(1, 8'h89, 8'h20); step(1, 8'h8D, 8'hF0); step(1, 8'h8B, 8'hFE); step(1, 8'h88, 8'h40);
    wait_ticks(2);
    rd(8'h8B, v); chk("m2 TL1", v, 8'hF0);
    rd(8'h8D, v); chk("m2 TH1", v, 8'hF0);
    chk("m2 tf1_irq", {7'd0, tf1_irq}, 8'h01);
    tf1_ack = 1; run(1); tf1_ack = 0;
    rd(8'h88, v); chk("m2 ack TCON", v, 8'h40);
    chk("m2 ack irq", {7'd0, tf1_irq}, 8'h00);
    check_all("m2");

    // Gate via int0_n
    do_reset();
    int0_n = 0;
    step(1, 8'h89, 8'h09); step(1, 8'h88, 8'h10);
    wait_ticks(10);
    rd(8'h8A, v); chk("gate closed TL0", v, 8'h00);
    int0_n = 1;
    wait_ticks(3);
    rd(8'h8A, v); chk("gate open TL0", v, 8'h03);
    check_all("gate");

    // Counter mode on falling edges of t0_pin
    do_reset();
    step(1, 8'h89, 8'h05); step(1, 8'h88, 8'h10);
    for (int i = 0; i < 4; i++) begin
      t0_pin = 0; run(2 * P);
      t0_pin = 1; run(2 * P);
    end
    rd(8'h8A, v); chk("counter 4 edges", v, 8'h04);
    run(5 * P);
    rd(8'h8A, v); chk("counter level high", v, 8'h04);
    check_all("counter");

    // Write collisions in the overflow clock
    do_reset();
    step(1, 8'h89, 8'h01); step(1, 8'h8C, 8'hFF); step(1, 8'h8A, 8'hFF); step(1, 8'h88, 8'h10);
    wait_next_tick();
    step(1, 8'h8A, 8'h55);
    rd(8'h8A, v); chk("coll TL0 write wins", v, 8'h55);
    rd(8'h8C, v); chk("coll TH0 wraps", v, 8'h00);
    rd(8'h88, v); chk("coll TF0 set", v, 8'h30);
    step(1, 8'h88, 8'h10); step(1, 8'h8C, 8'hFF); step(1, 8'h8A, 8'hFF);
    wait_next_tick();
    step(1, 8'h88, 8'h00);
    rd(8'h88, v); chk("coll TCON write", v, 8'h20);
    rd(8'h8A, v); chk("coll TL0 wraps", v, 8'h00);
    check_all("coll");

    // Reset in the middle of counting
    do_reset();
    step(1, 8'h89, 8'h01); step(1, 8'h8A, 8'h7E); step(1, 8'h88, 8'h90);
    b = 0;
    while (m_tl0 != 8'h80 && b < 4 * P) begin run(1); b++; end
    rd(8'h8A, v); chk("pre-reset TL0", v, 8'h80);
    do_reset();
    for (int a = 8'h88; a <= 8'h8D; a++) begin rd(8'(a), v); chk("mid reset sfr", v, 8'h00); end
    chk("mid reset irqs", {6'd0, tf1_irq, tf0_irq}, 8'h00);
    wait_ticks(3);
    rd(8'h8A, v); chk("stopped TL0", v, 8'h00);

    // Randomized traffic against the model
    step(1, 8'h89, 8'($urandom)); step(1, 8'h88, 8'h50);
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a, d;
      if ($urandom_range(7) == 0)  t0_pin = ~t0_pin;
      if ($urandom_range(7) == 0)  t1_pin = ~t1_pin;
      if ($urandom_range(15) == 0) int0_n = ~int0_n;
      if ($urandom_range(15) == 0) int1_n = ~int1_n;
      tf0_ack = ($urandom_range(7) == 0);
      tf1_ack = ($urandom_range(7) == 0);
      rst_n = ($urandom_range(499) != 0);
      a = 8'($urandom_range(8'h8E, 8'h87));
      d = ($urandom_range(1) == 0) ? (8'hF0 | 8'($urandom_range(15))) : 8'($urandom);
      if (a == 8'h88) d = d | 8'h50;
      step($urandom_range(9) == 0, a, d);
      tf0_ack = 0; tf1_ack = 0; rst_n = 1;
      check_all($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_unit.md
TIMER_UNIT -- requirements
Module: timer_unit

Interface
REQ-001 SHALL provide parameter PRESCALE, default 12: clk cycles per machine-cycle tick.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-004 SHALL provide port sfr_addr  input  8  SFR address from the MCU bus decode.
REQ-005 SHALL provide port sfr_wdata  input  8  SFR write data.
REQ-006 SHALL provide port sfr_we  input  1  SFR write strobe, one clk per write.
REQ-007 SHALL provide port sfr_rdata  output  8  SFR read data, combinational from sfr_addr.
REQ-008 SHALL provide ports t0_pin, t1_pin  input  1 each  external count inputs (P3.4/P3.5).
REQ-009 SHALL provide ports int0_n, int1_n  input  1 each  gate inputs (P3.2/P3.3).
REQ-010 SHALL provide ports tf0_ack, tf1_ack  input  1 each  interrupt-vector acknowledge; clears flag.
REQ-011 SHALL provide ports tf0_irq, tf1_irq  output  1 each  mirror of TCON.TF0 (bit5) / TCON.TF1 (bit7).

Function
REQ-012 SHALL own TCON 0x88, TMOD 0x89, TL0 0x8A, TL1 0x8B, TH0 0x8C, TH1 0x8D; sfr_rdata = addressed register, 0x00 for any other address.
REQ-013 SHALL generate a one-clk tick when a prescale counter reaches PRESCALE-1, then wrap to 0; counter free-runs from reset.
REQ-014 SHALL define run_x = TCON.TRx AND (NOT TMOD.GATEx OR intx_n); TR0/TR1 = TCON bit4/bit6.
REQ-015 SHALL, in timer mode (C/T=0), count once per tick while run_x.
REQ-016 SHALL, in counter mode (C/T=1), sample tx_pin on each tick and count once when previous sample 1 and current sample 0, while run_x.
REQ-017 SHALL implement mode 0: 13-bit counter TH[7:0]:TL[4:0]; TL[7:5] hold; overflow at 0x1FFF->0.
REQ-018 SHALL implement mode 1: 16-bit TH:TL; overflow at 0xFFFF->0x0000.
REQ-019 SHALL implement mode 2: TL 8-bit; on TL 0xFF overflow load TL<=TH in same clk; TH unchanged.
REQ-020 SHALL implement mode 3 for timer 0: TL0 8-bit under T0 controls, sets TF0; TH0 8-bit timer-only on ticks gated by TR1 alone, sets TF1; timer 1 in mode 3 holds its count.
REQ-021 SHALL set TFx in the clk the overflowing increment is applied (count register and flag update together).
REQ-022 SHALL clear TFx on tfx_ack; hardware set in the same clk takes priority over ack.
REQ-023 SHALL give a CPU write to TL/TH priority over a same-clk increment or reload of that register.
REQ-024 SHALL, on a CPU TCON write in the same clk as a hardware TF set, write all bits from sfr_wdata except that TF bit, which ends 1.
REQ-025 SHALL store TCON[3:0] as plain read/write bits with no internal function.
REQ-026 SHALL apply TMOD changes from the clk after the write; counts are not cleared on mode change.

Reset
REQ-027 SHALL, when rst_n=0 at a clk edge, clear TCON, TMOD, TL0, TL1, TH0, TH1, prescale counter to 0, and set both pin samplers to 1.
REQ-028 SHALL hold tf0_irq=tf1_irq=0 and sfr_rdata=0x00 (for any decoded address) from the first clk after reset until updated.
REQ-029 SHALL abort any count in progress on reset mid-operation; no flag survives reset.

Verification
REQ-030 Mode 1: TMOD=0x01, TH0:TL0=0xFFFE, TCON=0x10 -> TF0=1 and count 0x0000 after exactly 2 ticks (24 clk).
REQ-031 Mode 2: TMOD=0x20, TH1=0xF0, TL1=0xFE, TR1=1 -> after 2 ticks TL1=0xF0, TF1=1; tf1_ack -> TF1=0 next clk.
REQ-032 Gate: TMOD=0x09, TR0=1, int0_n=0 for 10 ticks -> TL0 unchanged; int0_n=1 for 3 ticks -> TL0=0x03.
REQ-033 Counter: TMOD=0x05, TR0=1, 4 falling edges on t0_pin each held >=2 ticks -> TL0=0x04; level-high pin alone -> no count.
REQ-034 Collisions: TL0 write 0x55 in the overflow clk -> TL0=0x55; TCON write 0x00 same clk as TF0 set -> TCON=0x20.
REQ-035 Reset mid-count: rst_n=0 for one clk while counting at TL0=0x80 -> all six SFRs 0x00, irqs 0, counting stops.
